branch_predictor: RTL and testbench

- Dynamic branch predictor: a direct-mapped branch history table of 2-bit saturating counters plus a branch target buffer.
- IF stage looks it up combinationally with the fetch PC.
- EX stage trains it with the resolved outcome: the branch comparator's taken flag and the computed target.
- On a mismatch with the prediction carried down the pipe, it emits a registered flush pulse and redirect PC to the PC mux and the pipeline registers.

---
 rtl/branch_predictor.sv | 124 ++++++++++++
 tb/tb_branch_predictor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped table of 2-bit counters plus BTB, looked up
// combinationally at fetch and trained by resolved branches; raises a registered flush.
module branch_predictor #(
  parameter int unsigned IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int unsigned Entries = 2 ** IDX_BITS;
  localparam int unsigned TagW    = 30 - IDX_BITS;

  logic [Entries-1:0] valid_q;
  logic [1:0]         ctr_q [Entries];
  logic [TagW-1:0]    tag_q [Entries];
  logic [31:0]        tgt_q [Entries];

  logic        flush_q, flush_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] br_q, br_d;
  logic [31:0] mis_q, mis_d;

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TagW-1:0]     if_tag, ex_tag;
  logic                if_hit, ex_hit;
  logic                upd, mis, tbl_we;
  logic [1:0]          ctr_d;

  // Lookup reads only registered table state, so ex_* never reaches pred_*.
  assign if_idx      = if_pc[IDX_BITS+1:2];
  assign if_tag      = if_pc[31:IDX_BITS+2];
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + 32'd4;

  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[31:IDX_BITS+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // A resolving branch during the flush cycle is wrong-path and is dropped.
  assign upd = ex_valid && !flush_q;
  assign mis = (ex_taken != ex_pred_taken) ||
               (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));

  always_comb begin
    ctr_d  = ctr_q[ex_idx];
    tbl_we = 1'b0;
    if (upd) begin
      if (ex_hit) begin
        tbl_we = 1'b1;
        if (ex_taken) begin
          ctr_d = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
        end else begin
          ctr_d = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        tbl_we = 1'b1;
        ctr_d  = 2'b10;
      end
    end
  end

  always_comb begin
    flush_d    = upd && mis;
    redirect_d = redirect_q;
    if (upd && mis) begin
      redirect_d = ex_taken ? ex_target : ex_pc + 32'd4;
    end
    br_d  = br_q + {31'b0, upd};
    mis_d = mis_q + {31'b0, upd && mis};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < Entries; i++) begin
        ctr_q[i] <= 2'b01;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (tbl_we) begin
      // Rewriting valid/tag on a hit is a no-op; on a miss it allocates over the old entry.
      valid_q[ex_idx] <= 1'b1;
      tag_q[ex_idx]   <= ex_tag;
      ctr_q[ex_idx]   <= ctr_d;
      if (ex_taken) begin
        tgt_q[ex_idx] <= ex_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
      br_q       <= '0;
      mis_q      <= '0;
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      br_q       <= br_d;
      mis_q      <= mis_d;
    end
  end

  assign flush         = flush_q;
  assign redirect_pc   = redirect_q;
  assign br_count      = br_q;
  assign mispred_count = mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expected observations,
// a negedge monitor pops and compares them.
module tb_branch_predictor;

  logic        clk, rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        flush;
  logic [31:0] redirect_pc, br_count, mispred_count;

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;   // 0: prediction, 1: counters, 2: flush/redirect level
    logic [31:0] a;
    logic [31:0] b;
  } obs_t;

  typedef struct {
    string       name;
    int          due;
    logic [31:0] pc;
  } fl_t;

  obs_t sq[$];
  fl_t  fq[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    obs_t o;
    fl_t  f;
    while (sq.size() > 0) begin
      o = sq.pop_front();
      case (o.kind)
        0: begin
          check({o.name, ".taken"}, {31'b0, pred_taken}, o.a);
          check({o.name, ".target"}, pred_target, o.b);
        end
        1: begin
          check({o.name, ".br_count"}, br_count, o.a);
          check({o.name, ".mispred_count"}, mispred_count, o.b);
        end
        default: begin
          check({o.name, ".flush"}, {31'b0, flush}, o.a);
          check({o.name, ".redirect_pc"}, redirect_pc, o.b);
        end
      endcase
    end
    while (fq.size() > 0 && fq[0].due < cyc) begin
      f = fq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: flush got 0 expected 1", f.name);
    end
    if (flush) begin
      if (fq.size() > 0 && fq[0].due == cyc) begin
        f = fq.pop_front();
        check({f.name, ".redirect"}, redirect_pc, f.pc);
      end else begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_flush: flush got 1 expected 0 (cycle %0d)", cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  task automatic look(input string n, input logic [31:0] pc, input logic t,
                      input logic [31:0] tg);
    obs_t o;
    if_pc  = pc;
    o.name = n;
    o.kind = 0;
    o.a    = {31'b0, t};
    o.b    = tg;
    sq.push_back(o);
  endtask

  task automatic cnt(input string n, input logic [31:0] br, input logic [31:0] mp);
    obs_t o;
    o.name = n;
    o.kind = 1;
    o.a    = br;
    o.b    = mp;
    sq.push_back(o);
  endtask

  task automatic redir(input string n, input logic fl, input logic [31:0] pc);
    obs_t o;
    o.name = n;
    o.kind = 2;
    o.a    = {31'b0, fl};
    o.b    = pc;
    sq.push_back(o);
  endtask

  task automatic upd(input string n, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tg, input logic ptk, input logic [31:0] ptg,
                     input logic exp_mis, input logic [31:0] exp_rd);
    fl_t f;
    ex_valid       = 1'b1;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tg;
    ex_pred_taken  = ptk;
    ex_pred_target = ptg;
    if (exp_mis) begin
      f.name = n;
      f.due  = cyc + 1;
      f.pc   = exp_rd;
      fq.push_back(f);
    end
  endtask

  initial begin
    rst            = 1'b1;
    if_pc          = 32'h0;
    ex_valid       = 1'b0;
    ex_pc          = 32'h0;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and cold taken branch
    look("reset_lookup", 32'h100, 1'b0, 32'h104);
    cnt("reset_counts", 32'd0, 32'd0);
    redir("reset_redirect", 1'b0, 32'h0);
    upd("cold_taken", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    step();
    look("after_alloc", 32'h100, 1'b1, 32'h80);
    cnt("after_cold", 32'd1, 32'd1);

    // Saturation and hysteresis
    step();
    redir("flush_one_cycle", 1'b0, 32'h80);
    upd("taken1", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    upd("taken2", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    upd("taken3", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    upd("not_taken1", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    step();
    look("hysteresis", 32'h100, 1'b1, 32'h80);
    cnt("after_nt1", 32'd5, 32'd2);
    step();
    upd("not_taken2", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    step();
    look("flipped", 32'h100, 1'b0, 32'h104);
    cnt("after_nt2", 32'd6, 32'd3);

    // Aliasing at idx 0
    step();
    upd("alias_alloc", 32'h140, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
    step();
    look("alias_old_miss", 32'h100, 1'b0, 32'h104);
    cnt("after_alias", 32'd7, 32'd4);
    step();
    look("alias_new_hit", 32'h140, 1'b1, 32'h200);
    redir("redirect_held", 1'b0, 32'h200);

    // Target mismatch, then a squashed update in the flush cycle
    step();
    upd("target_mismatch", 32'h140, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1, 32'h90);
    step();
    upd("squashed", 32'h104, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
    look("retargeted", 32'h140, 1'b1, 32'h90);
    cnt("after_mismatch", 32'd8, 32'd5);
    step();
    look("squash_no_alloc", 32'h104, 1'b0, 32'h108);
    cnt("squash_no_count", 32'd8, 32'd5);

    // Same-cycle update and lookup
    step();
    look("same_cycle_old", 32'h140, 1'b1, 32'h90);
    upd("same_cycle_upd", 32'h140, 1'b1, 32'ha0, 1'b1, 32'h90, 1'b1, 32'ha0);
    step();
    look("same_cycle_new", 32'h140, 1'b1, 32'ha0);
    cnt("after_same_cycle", 32'd9, 32'd6);

    // Asynchronous reset while flush is high
    step();
    upd("pre_reset_mis", 32'h108, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 32'h400);
    step();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_flush_clear", {31'b0, flush}, 32'h0);
    check("async_redirect_clear", redirect_pc, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    look("post_reset_lookup", 32'h140, 1'b0, 32'h144);
    cnt("post_reset_counts", 32'd0, 32'd0);
    redir("post_reset_redirect", 1'b0, 32'h0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
